// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle main control FSM.
package mc_ctrl_pkg;

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_RD    = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WR    = 4'd5;
  localparam logic [3:0] ST_R_EXEC    = 4'd6;
  localparam logic [3:0] ST_R_WB      = 4'd7;
  localparam logic [3:0] ST_BRANCH    = 4'd8;
  localparam logic [3:0] ST_JUMP      = 4'd9;
  localparam logic [3:0] ST_ADDI_EXEC = 4'd10;
  localparam logic [3:0] ST_ADDI_WB   = 4'd11;

  typedef enum logic [3:0] {
    S_FETCH     = ST_FETCH,
    S_DECODE    = ST_DECODE,
    S_MEM_ADDR  = ST_MEM_ADDR,
    S_MEM_RD    = ST_MEM_RD,
    S_MEM_WB    = ST_MEM_WB,
    S_MEM_WR    = ST_MEM_WR,
    S_R_EXEC    = ST_R_EXEC,
    S_R_WB      = ST_R_WB,
    S_BRANCH    = ST_BRANCH,
    S_JUMP      = ST_JUMP,
    S_ADDI_EXEC = ST_ADDI_EXEC,
    S_ADDI_WB   = ST_ADDI_WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of FSM state (plus mem_ready in FETCH) into datapath controls.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  // Per-state control values; anything not named for a state stays 0.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC+4 are captured only on the cycle the read completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: begin
        alu_src_b = SRCB_FOUR;
      end
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control: state register, next-state logic, retire counter.
//
// state      | meaning
// FETCH      | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE     | precompute branch target, dispatch on opcode
// MEM_ADDR   | compute lw/sw effective address
// MEM_RD     | data read, wait for mem_ready
// MEM_WB     | write MDR to rt
// MEM_WR     | data write, wait for mem_ready
// R_EXEC     | ALU on A,B with funct
// R_WB       | write ALUOut to rd
// BRANCH     | compare A,B, load PC from ALUOut if equal
// JUMP       | load PC with jump target
// ADDI_EXEC  | A + sign-extended immediate
// ADDI_WB    | write ALUOut to rt
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_retired
);

  state_t           state_q;
  state_t           state_nxt;
  logic             illegal_c;
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  logic dec_pc_write;
  logic dec_pc_write_cond;
  logic dec_mem_read;
  logic dec_mem_write;
  logic dec_ir_write;
  logic dec_reg_write;

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_nxt;
  end

  // Next-state selection and illegal-opcode detection.
  always_comb begin
    state_nxt = state_q;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_RTYPE:     state_nxt = S_R_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDI_EXEC;
          default: begin
            illegal_c = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR:  state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB:    state_nxt = S_FETCH;
      S_MEM_WR:    if (mem_ready) state_nxt = S_FETCH;
      S_R_EXEC:    state_nxt = S_R_WB;
      S_R_WB:      state_nxt = S_FETCH;
      S_BRANCH:    state_nxt = S_FETCH;
      S_JUMP:      state_nxt = S_FETCH;
      S_ADDI_EXEC: state_nxt = S_ADDI_WB;
      S_ADDI_WB:   state_nxt = S_FETCH;
      default:     state_nxt = S_FETCH;
    endcase
  end

  // Every path back to FETCH except the illegal exit from DECODE completes an instruction.
  assign retire = (state_q != S_FETCH) && (state_q != S_DECODE) && (state_nxt == S_FETCH);

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_W'(1);
  end

  mc_ctrl_outdec u_outdec (
    .state         (state_q),
    .mem_ready     (mem_ready),
    .pc_write      (dec_pc_write),
    .pc_write_cond (dec_pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (dec_mem_read),
    .mem_write     (dec_mem_write),
    .ir_write      (dec_ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (dec_reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source)
  );

  // State already reads FETCH during reset, so only the write/request strobes need gating.
  assign pc_write      = dec_pc_write      & rst_n;
  assign pc_write_cond = dec_pc_write_cond & rst_n;
  assign mem_read      = dec_mem_read      & rst_n;
  assign mem_write     = dec_mem_write     & rst_n;
  assign ir_write      = dec_ir_write      & rst_n;
  assign reg_write     = dec_reg_write     & rst_n;

  assign state         = state_q;
  assign illegal       = illegal_c;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Cycle-accurate bench: each instruction is expanded into its phase sequence and compared.
module tb_mc_main_ctrl;
  import mc_ctrl_pkg::*;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [5:0]          opcode;
  logic                mem_ready;
  logic                pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic                mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]          alu_src_b, alu_op, pc_source;
  logic [3:0]          state;
  logic                illegal;
  logic [TB_CNT_W-1:0] instr_retired;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal;
  } ctl_t;

  ctl_t got;
  assign got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, state, illegal};

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  mc_main_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .illegal       (illegal),
    .instr_retired (instr_retired)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Control values each phase must show, written straight from the state table.
  function automatic ctl_t exp_ctl(input state_t ph, input bit mr, input logic [5:0] op);
    ctl_t e;
    e = '0;
    e.state = ph;
    case (ph)
      S_FETCH:     begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
      S_DECODE:    begin e.alu_src_b = 2'b11; e.illegal = !op_known(op); end
      S_MEM_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      S_MEM_RD:    begin e.mem_read = 1; e.i_or_d = 1; end
      S_MEM_WB:    begin e.reg_write = 1; e.mem_to_reg = 1; end
      S_MEM_WR:    begin e.mem_write = 1; e.i_or_d = 1; end
      S_R_EXEC:    begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      S_R_WB:      begin e.reg_write = 1; e.reg_dst = 1; end
      S_BRANCH:    begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
      S_JUMP:      begin e.pc_write = 1; e.pc_source = 2'b10; end
      S_ADDI_EXEC: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      S_ADDI_WB:   begin e.reg_write = 1; end
      default:     e = '0;
    endcase
    return e;
  endfunction

  // One clock of stimulus: drive inputs after the falling edge, then compare.
  task automatic step(input state_t ph, input logic [5:0] op, input bit mr);
    @(negedge clk);
    opcode    = op;
    mem_ready = mr;
    #1;
    chk($sformatf("ctl_%0d", ph), 32'(got), 32'(exp_ctl(ph, mr, op)));
    chk("cnt", 32'(instr_retired), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    ctl_t r;
    r = '0;
    r.alu_src_b = 2'b01;
    r.state     = S_FETCH;
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    exp_cnt = 0;
    chk("rst_ctl", 32'(got), 32'(r));
    chk("rst_cnt", 32'(instr_retired), 32'(exp_cnt));
    @(negedge clk);
    #1;
    chk("rst_hold", 32'(got), 32'(r));
    mem_ready = 1'b0;
    rst_n     = 1'b1;
  endtask

  // Expand one instruction into its phases; fw/mw are wait cycles in FETCH / data access.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
    for (int i = 0; i < fw; i++) step(S_FETCH, 6'($urandom), 1'b0);
    step(S_FETCH, 6'($urandom), 1'b1);
    step(S_DECODE, op, 1'($urandom));
    case (op)
      6'b100011: begin
        step(S_MEM_ADDR, op, 1'($urandom));
        for (int i = 0; i < mw; i++) step(S_MEM_RD, op, 1'b0);
        if (abort) begin
          do_reset();
          return;
        end
        step(S_MEM_RD, op, 1'b1);
        step(S_MEM_WB, op, 1'($urandom));
      end
      6'b101011: begin
        step(S_MEM_ADDR, op, 1'($urandom));
        for (int i = 0; i < mw; i++) step(S_MEM_WR, op, 1'b0);
        step(S_MEM_WR, op, 1'b1);
      end
      6'b000000: begin
        step(S_R_EXEC, op, 1'($urandom));
        step(S_R_WB, op, 1'($urandom));
      end
      6'b000100: step(S_BRANCH, op, 1'($urandom));
      6'b000010: step(S_JUMP, op, 1'($urandom));
      6'b001000: begin
        step(S_ADDI_EXEC, op, 1'($urandom));
        step(S_ADDI_WB, op, 1'($urandom));
      end
      default: ;
    endcase
    if (op_known(op)) exp_cnt = (exp_cnt + 1) % (1 << TB_CNT_W);
  endtask

  logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};

  initial begin
    logic [5:0] op;
    rst_n     = 1'b0;
    opcode    = 6'd0;
    mem_ready = 1'b0;
    do_reset();

    run_instr(6'b100011, 0, 0, 1'b0);   // lw, no waits
    run_instr(6'b101011, 0, 3, 1'b0);   // sw, three write waits
    run_instr(6'b000000, 0, 0, 1'b0);   // R-type, beq, j back to back
    run_instr(6'b000100, 0, 0, 1'b0);
    run_instr(6'b000010, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);   // illegal
    run_instr(6'b100011, 1, 2, 1'b1);   // lw aborted by reset in MEM_RD
    for (int i = 0; i < 17; i++) run_instr(6'b001000, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (op_known(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
    end
    step(S_FETCH, 6'($urandom), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Multicycle main control FSM for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath mux and enable, including the 2-bit ALU operation class consumed by the existing ALU control decoder. Sits beside the datapath; stalls on a single-ported memory ready handshake.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read, mem_write  out  1  memory request strobes
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback source: 0=ALUOut, 1=MDR
- reg_dst  out  1  dest reg: 0=rt, 1=rd
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=use funct
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state (debug)
- illegal  out  1  one-cycle pulse on unknown opcode
- instr_retired  out  CNT_W  completed-instruction count

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
- Outputs not listed for a state are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode: 100011/101011 -> MEM_ADDR; 000000 -> R_EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EXEC.
  - Any other opcode: illegal=1, next state FETCH, not counted as retired.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_RD if opcode=100011, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- instr_retired increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or ADDI_WB. Wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore decodes of the state register, except ir_write/pc_write in FETCH, which combine state with mem_ready.
- opcode is sampled only in DECODE and MEM_ADDR. The IR is stable there.
- Latency in cycles with zero wait states (mem_ready=1 on first request): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle. Strobes stay constant while waiting.
- mem_ready outside a memory state is ignored.
- Reset (rst_n low, async):
  - state=FETCH, instr_retired=0, illegal=0.
  - pc_write, pc_write_cond, ir_write, reg_write, mem_read and mem_write are forced 0 while rst_n=0.
  - Mux selects take their FETCH values: alu_src_b=01, others 0.
- Reset mid-instruction aborts it with no further writes. First mem_read is in the cycle after rst_n rises.

## Structure
- Package mc_ctrl_pkg holds:
  - state encoding (4-bit localparams);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - alu_op constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - alu_src_b and pc_source select constants.
- One sub-module: mc_ctrl_outdec, a purely combinational decode of state and mem_ready into the control outputs. The FSM register, next-state logic and counter stay in mc_main_ctrl.

## Test plan
- Reset, then lw (opcode 100011) with mem_ready=1 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH; reg_write=1, mem_to_reg=1 only in cycle 5; instr_retired=1.
- sw with mem_ready low for 3 cycles in MEM_WR -> mem_write=1, i_or_d=1 held 4 cycles; total 7 cycles; no reg_write.
- R-type then beq then j back-to-back -> alu_op 10 in R_EXEC; 01 with pc_write_cond=1 in BRANCH; pc_source=10, pc_write=1 in JUMP; instr_retired=3 after 10 cycles.
- Opcode 111111 -> illegal pulses 1 cycle in DECODE, returns to FETCH, instr_retired unchanged.
- rst_n asserted during MEM_RD -> state=FETCH immediately, mem_read=0 during reset, counter=0; normal fetch resumes after release.
- CNT_W=4, 17 addi instructions -> instr_retired wraps to 1.
